// File: rtl/vga_sync_monitor.sv
// Receive-side VGA timing monitor: recovers pixel coordinates from hsync/vsync,
// locks to the expected timing, flags violations and produces a per-frame checksum and probe capture.
module vga_sync_monitor #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p_tick,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [11:0] rgb,
  input  logic [9:0]  probe_x,
  input  logic [9:0]  probe_y,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        de,
  output logic        locked,
  output logic        frame_start,
  output logic [15:0] frame_sum,
  output logic [7:0]  frame_count,
  output logic [11:0] probe_rgb,
  output logic        h_err,
  output logic        v_err,
  output logic        blank_err
);

  localparam int unsigned CW       = 10;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic          hs_d_q, hs_d_d, vs_d_q, vs_d_d;
  logic [15:0]   acc_q, acc_d;
  logic [11:0]   pend_q, pend_d;
  logic [9:0]    x_q, x_d, y_q, y_d;
  logic          de_q, de_d, locked_q, locked_d, frame_start_q, frame_start_d;
  logic [15:0]   frame_sum_q, frame_sum_d;
  logic [7:0]    frame_count_q, frame_count_d;
  logic [11:0]   probe_rgb_q, probe_rgb_d;
  logic          h_err_q, h_err_d, v_err_q, v_err_d, blank_err_q, blank_err_d;

  logic          hs_act, vs_act, hs_rise, hs_fall, vs_rise, vs_fall;
  logic          h_wrap, h_mis, v_mis, pix_de;
  logic [CW-1:0] hcnt_inc, vcnt_inc;

  always_comb begin
    state_d       = state_q;
    hcnt_d        = hcnt_q;
    vcnt_d        = vcnt_q;
    hs_d_d        = hs_d_q;
    vs_d_d        = vs_d_q;
    acc_d         = acc_q;
    pend_d        = pend_q;
    x_d           = x_q;
    y_d           = y_q;
    de_d          = de_q;
    frame_start_d = 1'b0;
    frame_sum_d   = frame_sum_q;
    frame_count_d = frame_count_q;
    probe_rgb_d   = probe_rgb_q;
    h_err_d       = h_err_q;
    v_err_d       = v_err_q;
    blank_err_d   = blank_err_q;

    hs_act  = (hsync == SYNC_POL);
    vs_act  = (vsync == SYNC_POL);
    hs_rise = hs_act && !hs_d_q;
    hs_fall = !hs_act && hs_d_q;
    vs_rise = vs_act && !vs_d_q;
    vs_fall = !vs_act && vs_d_q;

    // Position this p_tick's pixel would occupy if the timing is as predicted
    h_wrap   = (hcnt_q == CW'(H_TOTAL - 1));
    hcnt_inc = h_wrap ? '0 : hcnt_q + CW'(1);
    if (h_wrap) vcnt_inc = (vcnt_q == CW'(V_TOTAL - 1)) ? '0 : vcnt_q + CW'(1);
    else        vcnt_inc = vcnt_q;
    pix_de = (hcnt_inc < CW'(H_ACTIVE)) && (vcnt_inc < CW'(V_ACTIVE));

    // An unexpected edge and a missing expected edge are both mismatches
    h_mis = (hs_rise != (hcnt_inc == CW'(HS_START))) ||
            (hs_fall != (hcnt_inc == CW'(HS_END)));
    v_mis = (vs_rise != ((hcnt_inc == CW'(HS_START)) && (vcnt_inc == CW'(VS_START)))) ||
            (vs_fall && (vcnt_inc != CW'(VS_END))) ||
            (vs_act && (vcnt_inc == CW'(VS_END)) && (hcnt_inc == CW'(H_TOTAL - 1)));

    if (p_tick) begin
      hs_d_d = hs_act;
      vs_d_d = vs_act;
      if (state_q == SEARCH) begin
        hcnt_d = '0;
        vcnt_d = '0;
        x_d    = '0;
        y_d    = '0;
        de_d   = 1'b0;
        if (vs_rise) begin
          state_d = ALIGN;
          hcnt_d  = CW'(HS_START);
          vcnt_d  = CW'(VS_START);
          x_d     = 10'(HS_START);
          y_d     = 10'(VS_START);
        end
      end else begin
        if ((state_q == LOCKED) && (rgb != 12'h000) && !pix_de) blank_err_d = 1'b1;
        if (h_mis || v_mis) begin
          if (state_q == LOCKED) begin
            h_err_d = h_err_q | h_mis;
            v_err_d = v_err_q | v_mis;
          end
          state_d = SEARCH;
          hcnt_d  = '0;
          vcnt_d  = '0;
          x_d     = '0;
          y_d     = '0;
          de_d    = 1'b0;
          acc_d   = '0;
        end else begin
          hcnt_d = hcnt_inc;
          vcnt_d = vcnt_inc;
          x_d    = 10'(hcnt_inc);
          y_d    = 10'(vcnt_inc);
          de_d   = pix_de;
          if ((state_q == LOCKED) && pix_de) begin
            acc_d = acc_q + 16'(rgb);
            if ((10'(hcnt_inc) == probe_x) && (10'(vcnt_inc) == probe_y)) pend_d = rgb;
          end
          if (vs_rise) begin
            if (state_q == ALIGN) begin
              state_d = LOCKED;
            end else begin
              frame_sum_d   = acc_q;
              acc_d         = '0;
              frame_start_d = 1'b1;
              frame_count_d = frame_count_q + 8'(1);
              probe_rgb_d   = pend_q;
            end
          end
        end
      end
    end
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= SEARCH;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      hs_d_q        <= 1'b0;
      vs_d_q        <= 1'b0;
      acc_q         <= '0;
      pend_q        <= '0;
      x_q           <= '0;
      y_q           <= '0;
      de_q          <= 1'b0;
      locked_q      <= 1'b0;
      frame_start_q <= 1'b0;
      frame_sum_q   <= '0;
      frame_count_q <= '0;
      probe_rgb_q   <= '0;
      h_err_q       <= 1'b0;
      v_err_q       <= 1'b0;
      blank_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      hs_d_q        <= hs_d_d;
      vs_d_q        <= vs_d_d;
      acc_q         <= acc_d;
      pend_q        <= pend_d;
      x_q           <= x_d;
      y_q           <= y_d;
      de_q          <= de_d;
      locked_q      <= locked_d;
      frame_start_q <= frame_start_d;
      frame_sum_q   <= frame_sum_d;
      frame_count_q <= frame_count_d;
      probe_rgb_q   <= probe_rgb_d;
      h_err_q       <= h_err_d;
      v_err_q       <= v_err_d;
      blank_err_q   <= blank_err_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign de          = de_q;
  assign locked      = locked_q;
  assign frame_start = frame_start_q;
  assign frame_sum   = frame_sum_q;
  assign frame_count = frame_count_q;
  assign probe_rgb   = probe_rgb_q;
  assign h_err       = h_err_q;
  assign v_err       = v_err_q;
  assign blank_err   = blank_err_q;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Bench for vga_sync_monitor on a scaled-down raster (25x19 ticks) so whole frames stay short.
module tb_vga_sync_monitor;

  localparam int HA = 16, HF = 2, HSY = 4, HB = 3;
  localparam int VA = 12, VF = 2, VSY = 2, VB = 3;
  localparam int HT = HA + HF + HSY + HB;       // 25
  localparam int VT = VA + VF + VSY + VB;       // 19
  localparam int FRAME = HT * VT;               // 475
  localparam int HSS = HA + HF, HSE = HSS + HSY; // 18, 22
  localparam int VSS = VA + VF, VSE = VSS + VSY; // 14, 16
  localparam int VSPOS = VSS * HT + HSS;
  localparam int VEPOS = VSE * HT + HSS;
  localparam bit POL = 1'b0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, p_tick, hsync, vsync;
  logic [11:0] rgb;
  logic [9:0]  probe_x, probe_y;
  logic [9:0]  x, y;
  logic        de, locked, frame_start, h_err, v_err, blank_err;
  logic [15:0] frame_sum;
  logic [7:0]  frame_count;
  logic [11:0] probe_rgb;

  vga_sync_monitor #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB), .SYNC_POL(POL)
  ) dut (
    .clk(clk), .reset(reset), .p_tick(p_tick), .hsync(hsync), .vsync(vsync),
    .rgb(rgb), .probe_x(probe_x), .probe_y(probe_y), .x(x), .y(y), .de(de),
    .locked(locked), .frame_start(frame_start), .frame_sum(frame_sum),
    .frame_count(frame_count), .probe_rgb(probe_rgb), .h_err(h_err),
    .v_err(v_err), .blank_err(blank_err)
  );

  int n_cmp = 0, n_bad = 0;

  // Stream generator state
  int gen_p = 0, last_h = -1, last_v = -1;
  int rgb_mode = 0, fault_v = -1;
  bit inj_blank = 1'b0;

  // Model state: mode 0 searching, 1 aligning, 2 locked
  int m_mode = 0, m_ticks = 0, m_sum = 0;
  bit m_phs = 1'b0, m_pvs = 1'b0;
  int m_pend = 0;
  int e_x = 0, e_y = 0, e_sum = 0, e_fc = 0, e_probe = 0;
  bit e_de = 0, e_lk = 0, e_fs = 0, e_he = 0, e_ve = 0, e_be = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] gen_rgb(input int h, input int v);
    logic [11:0] c;
    c = 12'h000;
    if (rgb_mode == 1 && h < HA && v < VA) c = 12'h001;
    if (rgb_mode == 2 && h == 5 && v == 3) c = 12'hABC;
    if (inj_blank && h == 20 && v == 1) c = 12'hFFF;
    return c;
  endfunction

  // Expected outputs from the position predicted since the anchoring vsync edge
  task automatic model_step(input bit pt, input bit rst, input bit hs, input bit vs, input int c);
    bit hr, hf, vr, vf, hm, vm, dpx;
    int p, h, v;
    e_fs = 1'b0;
    if (rst) begin
      m_mode = 0; m_sum = 0; m_pend = 0; m_phs = 0; m_pvs = 0;
      e_x = 0; e_y = 0; e_de = 0; e_sum = 0; e_fc = 0; e_probe = 0;
      e_he = 0; e_ve = 0; e_be = 0;
    end else if (pt) begin
      hr = hs && !m_phs; hf = !hs && m_phs;
      vr = vs && !m_pvs; vf = !vs && m_pvs;
      if (m_mode == 0) begin
        e_de = 0;
        if (vr) begin
          m_mode = 1; m_ticks = 0; e_x = HSS; e_y = VSS;
        end else begin
          e_x = 0; e_y = 0;
        end
      end else begin
        m_ticks++;
        p = (VSPOS + m_ticks) % FRAME;
        h = p % HT; v = p / HT;
        dpx = (h < HA) && (v < VA);
        hm = (hr != (h == HSS)) || (hf != (h == HSE));
        vm = (vr != (h == HSS && v == VSS)) || (vf && v != VSE) || (vs && v == VSE && h == HT - 1);
        if (m_mode == 2 && c != 0 && !dpx) e_be = 1;
        if (hm || vm) begin
          if (m_mode == 2) begin
            e_he = e_he | hm; e_ve = e_ve | vm;
          end
          m_mode = 0; m_sum = 0; e_x = 0; e_y = 0; e_de = 0;
        end else begin
          e_x = h; e_y = v; e_de = dpx;
          if (m_mode == 2 && dpx) begin
            m_sum += c;
            if (h == int'(probe_x) && v == int'(probe_y)) m_pend = c;
          end
          if (vr) begin
            if (m_mode == 1) m_mode = 2;
            else begin
              e_sum = m_sum % 65536; m_sum = 0; e_fs = 1;
              e_fc = (e_fc + 1) % 256; e_probe = m_pend;
            end
          end
        end
      end
      m_phs = hs; m_pvs = vs;
    end
    e_lk = (m_mode == 2);
  endtask

  task automatic cycle(input bit pt, input bit rst);
    int h, v;
    bit hs, vs;
    logic [11:0] c;
    @(negedge clk);
    h = gen_p % HT; v = gen_p / HT;
    hs = (h >= HSS && h < HSE) && !(v == fault_v && h == HSS);
    vs = (gen_p >= VSPOS && gen_p < VEPOS);
    c = gen_rgb(h, v);
    reset = rst; p_tick = pt; rgb = c;
    hsync = hs ? POL : ~POL;
    vsync = vs ? POL : ~POL;
    if (pt) begin
      last_h = h; last_v = v; gen_p = (gen_p + 1) % FRAME;
    end
    model_step(pt, rst, hs, vs, int'(c));
    @(posedge clk);
    #1;
    chk("x", 16'(x), 16'(e_x));
    chk("y", 16'(y), 16'(e_y));
    chk("de", 16'(de), 16'(e_de));
    chk("locked", 16'(locked), 16'(e_lk));
    chk("frame_start", 16'(frame_start), 16'(e_fs));
    chk("frame_sum", frame_sum, 16'(e_sum));
    chk("frame_count", 16'(frame_count), 16'(e_fc));
    chk("probe_rgb", 16'(probe_rgb), 16'(e_probe));
    chk("h_err", 16'(h_err), 16'(e_he));
    chk("v_err", 16'(v_err), 16'(e_ve));
    chk("blank_err", 16'(blank_err), 16'(e_be));
  endtask

  task automatic tick();
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
  endtask

  // Advance until the most recently sampled pixel is (h,v); bounded to one frame
  task automatic goto(input int h, input int v);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(last_h == h && last_v == v) && n <= FRAME + 2);
    if (!(last_h == h && last_v == v)) begin
      n_cmp++; n_bad++;
      $display("FAIL goto_timeout: got (%0d,%0d) expected (%0d,%0d)", last_h, last_v, h, v);
    end
  endtask

  initial begin
    reset = 1'b1; p_tick = 1'b0; hsync = ~POL; vsync = ~POL; rgb = 12'h000;
    probe_x = 10'd0; probe_y = 10'd0;
    repeat (3) cycle(1'b0, 1'b1);
    chk("rst_locked", 16'(locked), 16'h0);
    chk("rst_x", 16'(x), 16'h0);
    chk("rst_count", 16'(frame_count), 16'h0);

    // Clean stream: anchor, align one frame, lock, one full locked frame
    goto(HSS, VSS);
    chk("align_locked", 16'(locked), 16'h0);
    chk("align_x", 16'(x), 16'd18);
    chk("align_y", 16'(y), 16'd14);
    goto(HSS - 1, VSS);
    chk("prelock", 16'(locked), 16'h0);
    tick();
    chk("lock", 16'(locked), 16'h1);
    chk("lock_count", 16'(frame_count), 16'h0);
    goto(HSS, VSS);
    chk("frame1_count", 16'(frame_count), 16'h1);
    chk("frame1_start", 16'(frame_start), 16'h1);
    chk("frame1_sum", frame_sum, 16'h0000);
    chk("frame1_errs", {13'h0, h_err, v_err, blank_err}, 16'h0);

    // Constant colour 1 over the 16x12 active area
    rgb_mode = 1;
    goto(HSS, VSS);
    chk("ones_sum", frame_sum, 16'h00C0);
    chk("ones_count", 16'(frame_count), 16'h2);

    // Single pixel probe
    rgb_mode = 2; probe_x = 10'd5; probe_y = 10'd3;
    goto(5, 3);
    chk("probe_x", 16'(x), 16'd5);
    chk("probe_y", 16'(y), 16'd3);
    chk("probe_de", 16'(de), 16'h1);
    goto(HSS, VSS);
    chk("probe_rgb", 16'(probe_rgb), 16'h0ABC);
    chk("probe_sum", frame_sum, 16'h0ABC);

    // Probe outside the active area keeps the previous capture
    probe_x = 10'd30;
    goto(HSS, VSS);
    chk("probe_keep", 16'(probe_rgb), 16'h0ABC);

    // Late hsync assertion on line 7
    rgb_mode = 0; fault_v = 7;
    goto(HSS, 7);
    chk("herr_flag", 16'(h_err), 16'h1);
    chk("herr_unlock", 16'(locked), 16'h0);
    chk("herr_verr", 16'(v_err), 16'h0);
    fault_v = -1;
    goto(HSS, VSS);
    chk("relock_align", 16'(locked), 16'h0);
    goto(HSS, VSS);
    chk("relock", 16'(locked), 16'h1);
    chk("herr_sticky", 16'(h_err), 16'h1);

    // Colour in horizontal blanking
    inj_blank = 1'b1;
    goto(20, 1);
    chk("blank_flag", 16'(blank_err), 16'h1);
    chk("blank_locked", 16'(locked), 16'h1);
    inj_blank = 1'b0;

    // Reset mid-frame, coinciding with a p_tick
    goto(10, 10);
    cycle(1'b1, 1'b1);
    chk("mid_rst_locked", 16'(locked), 16'h0);
    chk("mid_rst_x", 16'(x), 16'h0);
    chk("mid_rst_herr", 16'(h_err), 16'h0);
    chk("mid_rst_count", 16'(frame_count), 16'h0);
    goto(HSS, VSS);
    chk("mid_rst_align", 16'(locked), 16'h0);
    goto(HSS, VSS);
    chk("mid_rst_relock", 16'(locked), 16'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_sync_monitor.md
Name: vga_sync_monitor

Overview:
- Receive-side counterpart of the VGA output path: consumes `hsync`, `vsync` and `rgb` exactly as they leave the top level, plus the shared `p_tick`.
- Recovers pixel coordinates and locks to the 640x480 timing. Reports any timing violation or non-blank pixel during blanking.
- Produces a per-frame pixel checksum and a single-pixel probe capture.
- Used on-chip for self-check and in benches as the scoreboard for every screen (start, single, multi, game over, continue).

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (ticks)
H_SYNC, 96, hsync pulse width (ticks)
H_BP, 48, horizontal back porch (ticks)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)

Ports:
clk  in  1  system clock (100 MHz)
reset  in  1  synchronous, active-high reset
p_tick  in  1  pixel enable; all inputs are sampled only on cycles with p_tick=1
hsync  in  1  horizontal sync under test
vsync  in  1  vertical sync under test
rgb  in  12  pixel colour under test
probe_x  in  10  column to capture
probe_y  in  10  row to capture
x  out  10  recovered column of the last sampled pixel
y  out  10  recovered row of the last sampled pixel
de  out  1  recovered display-enable (x<H_ACTIVE && y<V_ACTIVE)
locked  out  1  timing locked
frame_start  out  1  one-clk pulse at each frame boundary while locked
frame_sum  out  16  latched checksum of the previous frame
frame_count  out  8  frames completed while locked, wraps 255->0
probe_rgb  out  12  rgb captured at (probe_x, probe_y) in the last locked frame
h_err  out  1  sticky horizontal timing error
v_err  out  1  sticky vertical timing error
blank_err  out  1  sticky: rgb != 0 while de=0 and locked

Behaviour:
- Reset: every register and output is 0; FSM enters SEARCH. Reset wins over p_tick in the same cycle, including when asserted mid-frame.
- Derived constants:
  - H_TOTAL = 800, V_TOTAL = 525.
  - HS_START = H_ACTIVE+H_FP (656), HS_END = HS_START+H_SYNC (752).
  - VS_START = 480+10 = 490, VS_END = 492.
- Sync asserted level: `s_act = (sync == SYNC_POL)`. On each p_tick, the previous sampled level is kept in `hs_d`/`vs_d`. Edge detection compares the current sample with the previous one.
- hcnt runs on every p_tick and wraps at H_TOTAL-1 -> 0. On wrap, vcnt increments, wrapping at V_TOTAL-1 -> 0.
- FSM:
  - SEARCH: counters held at 0, x=y=0.
    - On the first vsync assertion edge, load hcnt=HS_START and vcnt=VS_START, then go to ALIGN.
  - ALIGN: counters free-run and checks are active, but errors do not set the sticky flags; any mismatch returns to SEARCH.
    - The next vsync assertion edge that lands on the predicted position (hcnt becoming HS_START with vcnt becoming VS_START) goes to LOCKED. This is exactly one clean frame later.
  - LOCKED: any mismatch sets the matching sticky flag and returns to SEARCH on the same p_tick.
- Checks (evaluated against the value the counter takes on this p_tick):
  - hsync assert edge only at hcnt=HS_START; hsync deassert edge only at hcnt=HS_END.
  - vsync assert edge only at hcnt=HS_START with vcnt=VS_START; vsync deassert edge only at vcnt=VS_END.
  - A missing expected edge is also a mismatch.
- Outputs: x, y and de are registered and valid the clk after the p_tick that sampled the pixel.
- Checksum: in LOCKED, acc += rgb (zero-extended, modulo 2^16) on every p_tick with de=1.
- Frame boundary in LOCKED (vsync assert edge):
  - frame_sum <= acc, acc <= 0.
  - frame_start pulses for 1 clk.
  - frame_count increments.
  - probe_rgb is updated from the pending capture register.
- Probe: the pending capture register loads rgb when de && hcnt==probe_x && vcnt==probe_y.
- probe_x/probe_y outside the active area: no capture occurs; probe_rgb keeps its old value.
- blank_err: checked only in LOCKED.
- Sticky flags clear only on reset.
- Relock after an error: follows the SEARCH -> ALIGN -> LOCKED path.

Test Plan:
- Reset, then a clean 640x480 stream, rgb=0 → locked=0 until the 2nd vsync assert edge (420000 p_ticks after the 1st), then locked=1; frame_count=1 after the following frame; all error flags 0.
- rgb=12'h001 across the whole active area → frame_sum=16'hB000 (307200 mod 65536).
- Only pixel (100,50)=12'hABC, probe=(100,50) → probe_rgb=12'hABC and frame_sum=16'h0ABC after that frame; x=100, y=50 with de=1 one clk after that p_tick.
- hsync assert delayed 1 tick on line 200 while locked → h_err=1 and locked=0 at that tick. Relock after 2 clean vsync edges; h_err stays 1.
- rgb=12'hFFF at x=700 (blanking) while locked → blank_err=1, locked stays 1.
- Reset asserted mid-frame at (300,300) → next clk: all outputs 0, SEARCH; the relock sequence repeats.
